// File: rtl/drop_controller.sv
// Column-drop responder: validates a confirmed column, drops the mover's piece to the lowest free cell, toggles the turn.
// Commit two cycles after the request (plus FALL time when DROP_ANIM_EN is defined); requests arriving while busy are dropped.
module drop_controller #(
    parameter int COLS       = 7,
    parameter int ROWS       = 6,
    parameter int ANIM_TICKS = 25_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           coulumnSelect,
    input  logic                 confirmMove,
    input  logic                 newGame,
    output logic                 busy,
    output logic                 moveDone,
    output logic                 moveReject,
    output logic                 currentPlayer,
    output logic [ROWS*COLS-1:0] boardP1,
    output logic [ROWS*COLS-1:0] boardP2,
    output logic [2:0]           lastRow,
    output logic [2:0]           lastCol,
    output logic                 fallValid,
    output logic [2:0]           fallRow,
    output logic                 boardFull
);

    localparam logic [3:0] COLS_L  = 4'(COLS);
    localparam logic [2:0] ROWS_L  = 3'(ROWS);
    localparam logic [5:0] CELLS_L = 6'(ROWS * COLS);

    typedef enum logic [1:0] {IDLE, CHECK, FALL, COMMIT} stateType;

    stateType    state, stateNext;
    logic [2:0]  colReg;
    logic [2:0]  target;
    logic [2:0]  height [8];
    logic [5:0]  pieceCount;
    logic [5:0]  cellIdx;
    logic        legal;

`ifdef DROP_ANIM_EN
    localparam int TW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
    logic [TW-1:0] tickCount;
    logic          tickDone;
    assign tickDone = (tickCount == TW'(ANIM_TICKS - 1));
`else
    assign fallValid = 1'b0;
    assign fallRow   = 3'd0;
`endif

    assign cellIdx = 6'(target) * 6'(COLS) + 6'(colReg);

    always_comb begin
        legal     = ({1'b0, colReg} < COLS_L) && (height[colReg] != ROWS_L);
        stateNext = state;
        case (state)
            IDLE:    if (confirmMove) stateNext = CHECK;
            CHECK: begin
                if (!legal)
                    stateNext = IDLE;
                else
`ifdef DROP_ANIM_EN
                    stateNext = FALL;
`else
                    stateNext = COMMIT;
`endif
            end
`ifdef DROP_ANIM_EN
            FALL:    if (tickDone && fallRow == target) stateNext = COMMIT;
`endif
            COMMIT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (newGame) stateNext = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            colReg        <= '0;
            target        <= '0;
            pieceCount    <= '0;
            busy          <= 1'b0;
            moveDone      <= 1'b0;
            moveReject    <= 1'b0;
            currentPlayer <= 1'b0;
            boardP1       <= '0;
            boardP2       <= '0;
            lastRow       <= '0;
            lastCol       <= '0;
            boardFull     <= 1'b0;
            for (int i = 0; i < 8; i++) height[i] <= '0;
`ifdef DROP_ANIM_EN
            fallValid     <= 1'b0;
            fallRow       <= '0;
            tickCount     <= '0;
`endif
        end else begin
            state      <= stateNext;
            moveDone   <= 1'b0;
            moveReject <= 1'b0;
            if (newGame) begin
                // New game wins over any in-flight move; the move is abandoned silently.
                busy          <= 1'b0;
                currentPlayer <= 1'b0;
                boardP1       <= '0;
                boardP2       <= '0;
                pieceCount    <= '0;
                boardFull     <= 1'b0;
                for (int i = 0; i < 8; i++) height[i] <= '0;
`ifdef DROP_ANIM_EN
                fallValid     <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (confirmMove) begin
                            colReg <= coulumnSelect;
                            busy   <= 1'b1;
                        end
                    end
                    CHECK: begin
                        if (!legal) begin
                            moveReject <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            target <= height[colReg];
`ifdef DROP_ANIM_EN
                            fallValid <= 1'b1;
                            fallRow   <= ROWS_L - 3'd1;
                            tickCount <= '0;
`endif
                        end
                    end
`ifdef DROP_ANIM_EN
                    FALL: begin
                        if (tickDone) begin
                            tickCount <= '0;
                            if (fallRow != target) fallRow <= fallRow - 3'd1;
                        end else begin
                            tickCount <= tickCount + 1'b1;
                        end
                    end
`endif
                    COMMIT: begin
                        if (currentPlayer) boardP2[cellIdx] <= 1'b1;
                        else               boardP1[cellIdx] <= 1'b1;
                        height[colReg] <= height[colReg] + 3'd1;
                        pieceCount     <= pieceCount + 6'd1;
                        lastRow        <= target;
                        lastCol        <= colReg;
                        currentPlayer  <= ~currentPlayer;
                        moveDone       <= 1'b1;
                        busy           <= 1'b0;
                        if (pieceCount + 6'd1 == CELLS_L) boardFull <= 1'b1;
`ifdef DROP_ANIM_EN
                        fallValid      <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
